// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic-blocks library.
//   MUL_IN_W  : multiplier operand width
//   MUL_OUT_W : multiplier product width
//   MUL_Z_RST : product register value while in reset
package arith_pkg;

  localparam int MUL_IN_W  = 4;
  localparam int MUL_OUT_W = 8;

  localparam logic [MUL_OUT_W-1:0] MUL_Z_RST = 8'h00;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the multiplier's adder array.
//   a, b  : addend bits
//   cin   : carry in (tied low where the cell acts as a half adder)
//   sum   : sum bit
//   cout  : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/multiplier_4bit.sv
// Unsigned 4x4 array multiplier with a registered 8-bit product.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : qualifies X/Y for capture on this edge
//   X, Y      : unsigned operands
//   Z         : registered product, held while in_valid is low
//   out_valid : one-cycle-delayed copy of in_valid
module multiplier_4bit
  import arith_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [MUL_IN_W-1:0]  X,
  input  logic [MUL_IN_W-1:0]  Y,
  output logic [MUL_OUT_W-1:0] Z,
  output logic                 out_valid
);

  // pp[i] is X gated by Y[i], i.e. pp[i][j] = X[j] & Y[i]
  logic [MUL_IN_W-1:0] pp [0:MUL_IN_W-1];

  // row_in[k] is the running sum shifted right by one: its low bit has already
  // been retired to Z[k], and the row carry-out enters at the top.
  logic [MUL_IN_W-1:0] row_in    [0:MUL_IN_W-1];
  logic [MUL_IN_W-1:0] row_sum   [1:MUL_IN_W-1];
  logic [MUL_IN_W-1:0] row_carry [1:MUL_IN_W-1];

  logic [MUL_OUT_W-1:0] product;

  for (genvar i = 0; i < MUL_IN_W; i++) begin : g_pp
    assign pp[i] = X & {MUL_IN_W{Y[i]}};
  end

  assign row_in[0] = {1'b0, pp[0][MUL_IN_W-1:1]};

  for (genvar k = 1; k < MUL_IN_W; k++) begin : g_row
    for (genvar j = 0; j < MUL_IN_W; j++) begin : g_cell
      logic cin;
      if (j == 0) begin : g_half
        assign cin = 1'b0;
      end else begin : g_full
        assign cin = row_carry[k][j-1];
      end
      full_adder u_fa (
        .a    (pp[k][j]),
        .b    (row_in[k-1][j]),
        .cin  (cin),
        .sum  (row_sum[k][j]),
        .cout (row_carry[k][j])
      );
    end
    assign row_in[k] = {row_carry[k][MUL_IN_W-1], row_sum[k][MUL_IN_W-1:1]};
  end

  // Low bits retire one per row; the last row's shifted sum forms Z[7:4].
  assign product = {row_in[3], row_sum[3][0], row_sum[2][0], row_sum[1][0], pp[0][0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z         <= MUL_Z_RST;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Z <= product;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_4bit.sv
module tb_multiplier_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b1;
  logic [3:0] X = 4'd15;
  logic [3:0] Y = 4'd15;
  logic [7:0] Z;
  logic       out_valid;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q [$];
  logic [7:0] last_z = 8'h00;

  multiplier_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .Z         (Z),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer product.
  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[7:0];
  endfunction

  // Drive one cycle of stimulus; a qualified pair queues the product it must yield.
  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    in_valid = v;
    X = x;
    Y = y;
    if (v && rst_n) exp_q.push_back(model(x, y));
  endtask

  // Directed vector whose expected product is a fixed literal.
  task automatic drive_lit(input logic [3:0] x, input logic [3:0] y, input logic [7:0] expv);
    @(negedge clk);
    in_valid = 1'b1;
    X = x;
    Y = y;
    exp_q.push_back(expv);
  endtask

  // Monitor: one edge after capture, either a queued product is due or Z must hold.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("reset_z", int'(Z), 0);
      check("reset_out_valid", int'(out_valid), 0);
    end else if (exp_q.size() > 0) begin
      check("out_valid", int'(out_valid), 1);
      check("z", int'(Z), int'(exp_q[0]));
      last_z = exp_q.pop_front();
    end else begin
      check("idle_out_valid", int'(out_valid), 0);
      check("hold_z", int'(Z), int'(last_z));
    end
  end

  initial begin
    // Reset asserted with live operands: outputs clear before any clock edge.
    #2;
    check("async_reset_z", int'(Z), 0);
    check("async_reset_out_valid", int'(out_valid), 0);
    repeat (3) @(negedge clk);
    // Release with 15x15 presented; the very next edge captures it.
    rst_n = 1'b1;
    exp_q.push_back(8'd225);

    // Directed vectors
    drive_lit(4'd2, 4'd4, 8'b0000_1000);
    drive_lit(4'd6, 4'd1, 8'b0000_0110);
    drive_lit(4'd6, 4'd0, 8'b0000_0000);
    drive_lit(4'd5, 4'd4, 8'b0001_0100);
    drive_lit(4'd15, 4'd15, 8'b1110_0001);

    // Hold: capture 20, then unqualified 9x9 must not disturb Z
    drive_lit(4'd5, 4'd4, 8'd20);
    repeat (3) drive(1'b0, 4'd9, 4'd9);

    // Back-to-back stream
    drive_lit(4'd3, 4'd3, 8'd9);
    drive_lit(4'd7, 4'd2, 8'd14);
    drive_lit(4'd15, 4'd1, 8'd15);
    drive(1'b0, 4'd0, 4'd0);

    // Exhaustive sweep, streamed
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(1'b1, 4'(a), 4'(b));
      end
    end
    drive(1'b0, 4'd0, 4'd0);

    // Randomized traffic with gaps
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Mid-stream reset: pending 3x5 is discarded, Z clears at once
    drive(1'b1, 4'd7, 4'd7);
    drive(1'b1, 4'd3, 4'd5);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_z = 8'h00;
    #1;
    check("midstream_reset_z", int'(Z), 0);
    check("midstream_reset_out_valid", int'(out_valid), 0);
    repeat (2) drive(1'b1, 4'd11, 4'd13);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    X = 4'd12;
    Y = 4'd10;
    exp_q.push_back(model(4'd12, 4'd10));
    drive(1'b1, 4'd13, 4'd14);
    repeat (3) drive(1'b0, 4'd1, 4'd1);

    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
